// File: rtl/gbdmg_square_voice.sv
// gbdmg_square_voice: DMG pulse voice with duty timer, length counter, volume envelope and frequency sweep
module gbdmg_square_voice #(
  parameter int FREQ_W  = 11,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 4
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_trigger,
  input  logic              in_freq_wr,
  input  logic [FREQ_W-1:0] in_freq,
  input  logic [1:0]        in_duty,
  input  logic              in_len_load,
  input  logic [LEN_W-1:0]  in_len_val,
  input  logic              in_len_en,
  input  logic [3:0]        in_env_vol,
  input  logic              in_env_dir,
  input  logic [2:0]        in_env_period,
  input  logic [2:0]        in_sweep_period,
  input  logic              in_sweep_dir,
  input  logic [2:0]        in_sweep_shift,
  input  logic              in_tick_len,
  input  logic              in_tick_env,
  input  logic              in_tick_sweep,
  output logic [3:0]        out_level,
  output logic              out_active,
  output logic [FREQ_W-1:0] out_freq
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [LEN_W:0] LEN_FULL = (LEN_W+1)'(2**LEN_W);

  logic [PW-1:0]     presc_q, presc_d;
  logic [FREQ_W-1:0] per_q, per_d, shadow_q, shadow_d;
  logic [2:0]        pos_q, pos_d, env_t_q, env_t_d;
  logic [LEN_W:0]    len_q, len_d;
  logic [3:0]        vol_q, vol_d, sw_t_q, sw_t_d;
  logic              active_q, active_d, sw_en_q, sw_en_d;
  logic              step;
  logic [3:0]        sw_reload;
  logic [FREQ_W:0]   calc_cur, calc_next, calc_trig;
  logic [7:0]        pattern;

  // FREQ_W+1 bit result; the top bit flags overflow in add mode
  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] f, input logic dir,
                                                 input logic [2:0] sh);
    logic [FREQ_W:0] e;
    e = {1'b0, f};
    return dir ? e - (e >> sh) : e + (e >> sh);
  endfunction

  assign step      = (CLK_DIV == 1) || (presc_q == PW'(CLK_DIV - 1));
  assign sw_reload = in_sweep_period == 3'd0 ? 4'd8 : {1'b0, in_sweep_period};
  assign calc_cur  = sweep_calc(shadow_q, in_sweep_dir, in_sweep_shift);
  assign calc_next = sweep_calc(calc_cur[FREQ_W-1:0], in_sweep_dir, in_sweep_shift);
  assign calc_trig = sweep_calc(in_freq, in_sweep_dir, in_sweep_shift);
  assign pattern   = in_duty == 2'd0 ? 8'b00000001 :
                     in_duty == 2'd1 ? 8'b10000001 :
                     in_duty == 2'd2 ? 8'b10000111 : 8'b01111110;
  assign out_level  = active_q && pattern[pos_q] ? vol_q : 4'd0;
  assign out_active = active_q;
  assign out_freq   = shadow_q;

  always_comb begin
    presc_d  = step ? '0 : presc_q + PW'(1);
    per_d    = per_q;
    pos_d    = pos_q;
    len_d    = len_q;
    vol_d    = vol_q;
    env_t_d  = env_t_q;
    shadow_d = shadow_q;
    sw_t_d   = sw_t_q;
    sw_en_d  = sw_en_q;
    active_d = active_q;
    if (step) begin
      per_d = &per_q ? shadow_q : per_q + FREQ_W'(1);
      pos_d = &per_q ? pos_q + 3'd1 : pos_q;
    end
    if (in_len_load)
      len_d = LEN_FULL - {1'b0, in_len_val};
    else if (in_tick_len && in_len_en && len_q != '0) begin
      len_d = len_q - (LEN_W+1)'(1);
      if (len_q == (LEN_W+1)'(1)) active_d = 1'b0;
    end
    if (in_tick_env && in_env_period != 3'd0) begin
      env_t_d = env_t_q <= 3'd1 ? in_env_period : env_t_q - 3'd1;
      if (env_t_q <= 3'd1)
        vol_d = in_env_dir ? (vol_q == 4'd15 ? vol_q : vol_q + 4'd1)
                           : (vol_q == 4'd0 ? vol_q : vol_q - 4'd1);
    end
    if (in_tick_sweep) begin
      sw_t_d = sw_t_q <= 4'd1 ? sw_reload : sw_t_q - 4'd1;
      // a same-cycle register write takes precedence over the sweep result
      if (sw_t_q <= 4'd1 && !in_freq_wr && sw_en_q && in_sweep_period != 3'd0) begin
        if (calc_cur[FREQ_W])
          active_d = 1'b0;
        else if (in_sweep_shift != 3'd0) begin
          shadow_d = calc_cur[FREQ_W-1:0];
          if (calc_next[FREQ_W] && !in_sweep_dir) active_d = 1'b0;
        end
      end
    end
    if (in_freq_wr) shadow_d = in_freq;
    if (in_trigger) begin
      active_d = (in_env_vol != 4'd0 || in_env_dir) &&
                 !(in_sweep_shift != 3'd0 && calc_trig[FREQ_W]);
      per_d    = in_freq;
      presc_d  = '0;
      len_d    = len_q == '0 ? LEN_FULL : len_q;
      vol_d    = in_env_vol;
      env_t_d  = in_env_period;
      shadow_d = in_freq;
      sw_t_d   = sw_reload;
      sw_en_d  = in_sweep_period != 3'd0 || in_sweep_shift != 3'd0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      presc_q  <= '0;
      per_q    <= '0;
      pos_q    <= '0;
      len_q    <= '0;
      vol_q    <= '0;
      env_t_q  <= '0;
      shadow_q <= '0;
      sw_t_q   <= '0;
      sw_en_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      per_q    <= per_d;
      pos_q    <= pos_d;
      len_q    <= len_d;
      vol_q    <= vol_d;
      env_t_q  <= env_t_d;
      shadow_q <= shadow_d;
      sw_t_q   <= sw_t_d;
      sw_en_q  <= sw_en_d;
      active_q <= active_d;
    end
  end
endmodule

// File: tb/tb_gbdmg_square_voice.sv
// tb_gbdmg_square_voice: directed checks of tone, length, envelope, sweep and event priority
module tb_gbdmg_square_voice;
  logic        in_clk = 1'b0, in_rst_n = 1'b0;
  logic        in_trigger = 1'b0, in_freq_wr = 1'b0, in_len_load = 1'b0, in_len_en = 1'b0;
  logic [10:0] in_freq = '0;
  logic [1:0]  in_duty = '0;
  logic [5:0]  in_len_val = '0;
  logic [3:0]  in_env_vol = '0;
  logic        in_env_dir = 1'b0, in_sweep_dir = 1'b0;
  logic [2:0]  in_env_period = '0, in_sweep_period = '0, in_sweep_shift = '0;
  logic        in_tick_len = 1'b0, in_tick_env = 1'b0, in_tick_sweep = 1'b0;
  logic [3:0]  out_level;
  logic        out_active;
  logic [10:0] out_freq;
  int          checks = 0, errors = 0;
  logic [3:0]  m;
  logic [3:0]  exp_lv [8] = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};

  gbdmg_square_voice dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_trigger(in_trigger), .in_freq_wr(in_freq_wr),
    .in_freq(in_freq), .in_duty(in_duty), .in_len_load(in_len_load), .in_len_val(in_len_val),
    .in_len_en(in_len_en), .in_env_vol(in_env_vol), .in_env_dir(in_env_dir),
    .in_env_period(in_env_period), .in_sweep_period(in_sweep_period),
    .in_sweep_dir(in_sweep_dir), .in_sweep_shift(in_sweep_shift), .in_tick_len(in_tick_len),
    .in_tick_env(in_tick_env), .in_tick_sweep(in_tick_sweep), .out_level(out_level),
    .out_active(out_active), .out_freq(out_freq)
  );

  always #5 in_clk = ~in_clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one full duty cycle at freq 0x7FC is 8 positions x 16 clocks
  task automatic maxlvl(output logic [3:0] mx);
    mx = 4'd0;
    repeat (128) begin
      cyc(1);
      if (out_level > mx) mx = out_level;
    end
  endtask

  task automatic trig();
    in_trigger = 1'b1; cyc(1); in_trigger = 1'b0;
  endtask

  task automatic tlen();
    in_tick_len = 1'b1; cyc(1); in_tick_len = 1'b0;
  endtask

  task automatic tenv();
    in_tick_env = 1'b1; cyc(1); in_tick_env = 1'b0;
  endtask

  task automatic tsw();
    in_tick_sweep = 1'b1; cyc(1); in_tick_sweep = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_level", 16'(out_level), 16'd0);
    chk("rst_active", 16'(out_active), 16'd0);
    chk("rst_freq", 16'(out_freq), 16'd0);
    in_rst_n = 1'b1;
    cyc(1);
    in_freq = 11'h7FC; in_duty = 2'd2; in_env_vol = 4'd15;
    trig();
    cyc(4);
    chk("tone_level", 16'(out_level), 16'd15);
    chk("tone_active", 16'(out_active), 16'd1);
    chk("tone_freq", 16'(out_freq), 16'h7FC);
    #2 in_rst_n = 1'b0;
    #1;
    chk("midrst_level", 16'(out_level), 16'd0);
    chk("midrst_active", 16'(out_active), 16'd0);
    chk("midrst_freq", 16'(out_freq), 16'd0);
    cyc(1);
    in_rst_n = 1'b1;
    trig();
    cyc(7);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("duty2_pos%0d", i), 16'(out_level), 16'(exp_lv[i]));
      cyc(16);
    end
    in_len_val = 6'd62;
    in_len_load = 1'b1; cyc(1); in_len_load = 1'b0;
    in_len_en = 1'b1;
    trig();
    chk("len_start", 16'(out_active), 16'd1);
    tlen();
    chk("len_tick1", 16'(out_active), 16'd1);
    tlen();
    chk("len_tick2", 16'(out_active), 16'd0);
    maxlvl(m);
    chk("len_off_level", 16'(m), 16'd0);
    in_len_en = 1'b0;
    in_env_vol = 4'd0; in_env_dir = 1'b0;
    trig();
    chk("dac_off", 16'(out_active), 16'd0);
    in_env_vol = 4'd2; in_env_period = 3'd1;
    trig();
    maxlvl(m);
    chk("env_v2", 16'(m), 16'd2);
    tenv(); maxlvl(m);
    chk("env_v1", 16'(m), 16'd1);
    tenv(); maxlvl(m);
    chk("env_v0", 16'(m), 16'd0);
    tenv(); maxlvl(m);
    chk("env_floor", 16'(m), 16'd0);
    in_env_vol = 4'd14; in_env_dir = 1'b1;
    trig();
    tenv(); maxlvl(m);
    chk("env_up15", 16'(m), 16'd15);
    tenv(); maxlvl(m);
    chk("env_ceil", 16'(m), 16'd15);
    in_env_vol = 4'd15; in_env_dir = 1'b0; in_env_period = 3'd0;
    in_sweep_period = 3'd1; in_sweep_shift = 3'd1; in_sweep_dir = 1'b0; in_freq = 11'h100;
    trig();
    chk("sw_start_active", 16'(out_active), 16'd1);
    chk("sw_start_freq", 16'(out_freq), 16'h100);
    tsw();
    chk("sw_add_freq", 16'(out_freq), 16'h180);
    chk("sw_add_active", 16'(out_active), 16'd1);
    in_freq = 11'h700;
    trig();
    chk("sw_ovf_active", 16'(out_active), 16'd0);
    chk("sw_ovf_freq", 16'(out_freq), 16'h700);
    in_freq = 11'h100; in_sweep_dir = 1'b1;
    trig();
    tsw();
    chk("sw_sub_freq", 16'(out_freq), 16'h080);
    chk("sw_sub_active", 16'(out_active), 16'd1);
    in_freq = 11'h234;
    in_freq_wr = 1'b1; cyc(1); in_freq_wr = 1'b0;
    chk("freq_wr", 16'(out_freq), 16'h234);
    in_freq = 11'h300;
    in_freq_wr = 1'b1; in_tick_sweep = 1'b1; cyc(1); in_freq_wr = 1'b0; in_tick_sweep = 1'b0;
    chk("freq_wr_beats_sweep", 16'(out_freq), 16'h300);
    in_sweep_period = 3'd0; in_sweep_shift = 3'd0; in_sweep_dir = 1'b0;
    in_freq = 11'h7FC; in_len_en = 1'b1; in_len_val = 6'd63;
    in_len_load = 1'b1; cyc(1); in_len_load = 1'b0;
    tlen();
    chk("len_zero", 16'(out_active), 16'd0);
    in_env_vol = 4'd9; in_env_period = 3'd1; in_len_val = 6'd10;
    in_trigger = 1'b1; in_tick_env = 1'b1; in_tick_len = 1'b1; in_len_load = 1'b1;
    cyc(1);
    in_trigger = 1'b0; in_tick_env = 1'b0; in_tick_len = 1'b0; in_len_load = 1'b0;
    chk("prio_active", 16'(out_active), 16'd1);
    maxlvl(m);
    chk("prio_vol", 16'(m), 16'd9);
    repeat (63) tlen();
    chk("prio_len63", 16'(out_active), 16'd1);
    tlen();
    chk("prio_len64", 16'(out_active), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
